// File: rtl/hdmi_capture_controller.sv
// rtl/hdmi_capture_controller.sv - vSync-aligned pixel word capture sequencer feeding the frame FIFO.
// Optional build macro FRAME_MARKER_EN prepends a {16'hF5A3, frame count} header word to each frame.
module hdmi_capture_controller #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int FCOUNT_W = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_vSync,
    input  logic                i_hSync,
    input  logic                i_dataValid,
    input  logic [31:0]         i_data,
    input  logic                i_fifoFull,
    output logic                o_fifoWrite,
    output logic [31:0]         o_fifoData,
    output logic                o_frameStart,
    output logic                o_busy,
    output logic                o_overflow,
    output logic                o_geometryError,
    output logic [FCOUNT_W-1:0] o_frameCount
);

    localparam int WORDS_PER_LINE = H_ACTIVE * 3 / 4;
    localparam int WC_W = $clog2(WORDS_PER_LINE + 1);
    localparam int LC_W = $clog2(V_ACTIVE + 1);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_LINE - 1);
    localparam logic [LC_W-1:0] LAST_LINE = LC_W'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VSYNC,
        S_ACTIVE,
        S_DROP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_vsync_q;
    logic              r_hsync_q;
    logic [WC_W-1:0]   r_word_cnt;
    logic [LC_W-1:0]   r_line_cnt;
    logic              r_first;

    logic              w_vs_rise;
    logic              w_hs_rise;
    logic              w_in_valid;
    logic [31:0]       w_in_data;
    logic              w_hdr_now;
    logic [15:0]       w_fc16;
    logic              w_write;
    logic              w_pix;
    logic [31:0]       w_wdata;
    logic              w_ovf_set;
    logic              w_geo_set;
    logic              w_geo;
    logic              w_last;
    logic              w_clr;
    logic              w_flag_clr;
    logic              w_frame_done;

    assign w_vs_rise = i_vSync & ~r_vsync_q;
    assign w_hs_rise = i_hSync & ~r_hsync_q;
    assign w_fc16    = 16'(o_frameCount);
    assign o_busy    = (r_state != S_IDLE);

`ifdef FRAME_MARKER_EN
    logic        r_hdr_pend;
    logic        r_skid_valid;
    logic [31:0] r_skid_data;

    // While the skid holds a word it is served first and the live input refills it.
    assign w_hdr_now  = r_hdr_pend;
    assign w_in_valid = r_skid_valid | i_dataValid;
    assign w_in_data  = r_skid_valid ? r_skid_data : i_data;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_hdr_pend   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            r_hdr_pend <= w_clr;
            if (r_state == S_ACTIVE && w_next == S_ACTIVE && (r_hdr_pend || r_skid_valid)) begin
                r_skid_valid <= i_dataValid;
                r_skid_data  <= i_data;
            end else begin
                r_skid_valid <= 1'b0;
            end
        end
    end
`else
    assign w_hdr_now  = 1'b0;
    assign w_in_valid = i_dataValid;
    assign w_in_data  = i_data;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_write      = 1'b0;
        w_pix        = 1'b0;
        w_wdata      = w_in_data;
        w_ovf_set    = 1'b0;
        w_geo_set    = 1'b0;
        w_clr        = 1'b0;
        w_flag_clr   = 1'b0;
        w_frame_done = 1'b0;
        w_geo  = (w_hs_rise && r_word_cnt != '0) ||
                 (w_vs_rise && (r_word_cnt != '0 || r_line_cnt != '0));
        w_last = (r_word_cnt == LAST_WORD) && (r_line_cnt == LAST_LINE);
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_next     = S_WAIT_VSYNC;
                    w_flag_clr = 1'b1;
                end
            end
            S_WAIT_VSYNC: begin
                if (!i_enable) begin
                    w_next = S_IDLE;
                end else if (w_vs_rise) begin
                    w_next = S_ACTIVE;
                    w_clr  = 1'b1;
                end
            end
            S_ACTIVE: begin
                w_geo_set = w_geo;
                if (w_hdr_now) begin
                    w_ovf_set = i_fifoFull;
                    w_write   = ~i_fifoFull & ~w_geo;
                    w_wdata   = {16'hF5A3, w_fc16};
                end else begin
                    w_ovf_set = w_in_valid & i_fifoFull;
                    w_pix     = w_in_valid & ~i_fifoFull & ~w_geo;
                    w_write   = w_pix;
                end
                if (w_ovf_set || w_geo_set) begin
                    w_next = S_DROP;
                end else if (w_pix && w_last) begin
                    w_frame_done = 1'b1;
                    w_next       = i_enable ? S_WAIT_VSYNC : S_IDLE;
                end
            end
            S_DROP: begin
                if (w_vs_rise) begin
                    if (i_enable) begin
                        w_next = S_ACTIVE;
                        w_clr  = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_vsync_q       <= 1'b0;
            r_hsync_q       <= 1'b0;
            r_word_cnt      <= '0;
            r_line_cnt      <= '0;
            r_first         <= 1'b0;
            o_fifoWrite     <= 1'b0;
            o_fifoData      <= '0;
            o_frameStart    <= 1'b0;
            o_overflow      <= 1'b0;
            o_geometryError <= 1'b0;
            o_frameCount    <= '0;
        end else begin
            r_vsync_q    <= i_vSync;
            r_hsync_q    <= i_hSync;
            o_fifoWrite  <= w_write;
            o_frameStart <= w_write & r_first;
            if (w_write) begin
                o_fifoData <= w_wdata;
                r_first    <= 1'b0;
            end
            if (w_clr) begin
                r_first    <= 1'b1;
                r_word_cnt <= '0;
                r_line_cnt <= '0;
            end else if (w_pix) begin
                if (r_word_cnt == LAST_WORD) begin
                    r_word_cnt <= '0;
                    r_line_cnt <= (r_line_cnt == LAST_LINE) ? '0 : r_line_cnt + LC_W'(1);
                end else begin
                    r_word_cnt <= r_word_cnt + WC_W'(1);
                end
            end
            if (w_frame_done) begin
                o_frameCount <= o_frameCount + FCOUNT_W'(1);
            end
            if (w_flag_clr) begin
                o_overflow      <= 1'b0;
                o_geometryError <= 1'b0;
            end else begin
                if (w_ovf_set) o_overflow      <= 1'b1;
                if (w_geo_set) o_geometryError <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_capture_controller.sv
// tb/tb_hdmi_capture_controller.sv - directed bench for hdmi_capture_controller (H_ACTIVE=8, V_ACTIVE=2).
// With FRAME_MARKER_EN defined each frame entry is expected to add one header write.
module tb_hdmi_capture_controller;

`ifdef FRAME_MARKER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clk = 1'b0;
    logic        i_reset, i_enable, i_vSync, i_hSync, i_dataValid, i_fifoFull;
    logic [31:0] i_data;
    logic        o_fifoWrite, o_frameStart, o_busy, o_overflow, o_geometryError;
    logic [31:0] o_fifoData;
    logic [15:0] o_frameCount;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] wq[$];
    logic        fsq[$];

    hdmi_capture_controller #(.H_ACTIVE(8), .V_ACTIVE(2), .FCOUNT_W(16)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_vSync(i_vSync),
        .i_hSync(i_hSync), .i_dataValid(i_dataValid), .i_data(i_data), .i_fifoFull(i_fifoFull),
        .o_fifoWrite(o_fifoWrite), .o_fifoData(o_fifoData), .o_frameStart(o_frameStart),
        .o_busy(o_busy), .o_overflow(o_overflow), .o_geometryError(o_geometryError),
        .o_frameCount(o_frameCount)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_fifoWrite) begin
            wq.push_back(o_fifoData);
            fsq.push_back(o_frameStart);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d);
        i_dataValid = 1'b1;
        i_data      = d;
        tick();
        i_dataValid = 1'b0;
    endtask

    task automatic vsync_pulse();
        i_vSync = 1'b1;
        tick();
        i_vSync = 1'b0;
        tick();
    endtask

    initial begin
        i_reset = 1'b1; i_enable = 1'b0; i_vSync = 1'b0; i_hSync = 1'b0;
        i_dataValid = 1'b0; i_fifoFull = 1'b0; i_data = '0;
        tick(); tick();
        chk("rst_write", 32'(o_fifoWrite), 32'd0);
        chk("rst_data", o_fifoData, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_fcount", 32'(o_frameCount), 32'd0);
        chk("rst_flags", {30'd0, o_overflow, o_geometryError}, 32'd0);

        // Frame 1: words before vSync are dropped, 12 words captured, hSync at line boundary is legal
        i_reset = 1'b0; i_enable = 1'b1;
        tick();
        chk("arm_busy", 32'(o_busy), 32'd1);
        send_word(32'hAAAA_0001); send_word(32'hAAAA_0002);
        tick();
        chk("pre_vsync_writes", 32'(wq.size()), 32'd0);
        vsync_pulse();
        for (int i = 0; i < 6; i++) send_word(32'(i));
        i_hSync = 1'b1; tick(); i_hSync = 1'b0;
        for (int i = 6; i < 12; i++) send_word(32'(i));
        tick();
        chk("f1_writes", 32'(wq.size()), 32'(12 + HDR));
`ifdef FRAME_MARKER_EN
        chk("f1_header", wq[0], 32'hF5A3_0000);
`endif
        for (int i = 0; i < 12; i++) chk("f1_word", wq[HDR + i], 32'(i));
        chk("f1_fs_first", 32'(fsq[0]), 32'd1);
        chk("f1_fs_second", 32'(fsq[1]), 32'd0);
        chk("f1_fcount", 32'(o_frameCount), 32'd1);
        chk("f1_geo_boundary", 32'(o_geometryError), 32'd0);
        chk("f1_busy_wait", 32'(o_busy), 32'd1);

        // Overflow on word 7, frame dropped, recovery on next vSync
        wq.delete(); fsq.delete();
        vsync_pulse();
        for (int i = 0; i < 12; i++) begin
            i_fifoFull = (i == 7);
            send_word(32'h100 + 32'(i));
        end
        i_fifoFull = 1'b0;
        tick();
        chk("ovf_writes", 32'(wq.size()), 32'(7 + HDR));
        chk("ovf_last_word", wq[wq.size() - 1], 32'h106);
        chk("ovf_flag", 32'(o_overflow), 32'd1);
        chk("ovf_fcount", 32'(o_frameCount), 32'd1);
        chk("ovf_busy_drop", 32'(o_busy), 32'd1);
        vsync_pulse();
        for (int i = 0; i < 12; i++) send_word(32'h200 + 32'(i));
        tick();
        chk("ovf_recover_writes", 32'(wq.size()), 32'(19 + 2 * HDR));
        chk("ovf_recover_fcount", 32'(o_frameCount), 32'd2);
        chk("ovf_sticky", 32'(o_overflow), 32'd1);

        // hSync mid-line -> geometry error, then a clean frame
        wq.delete(); fsq.delete();
        vsync_pulse();
        for (int i = 0; i < 4; i++) send_word(32'h300 + 32'(i));
        i_hSync = 1'b1; tick(); i_hSync = 1'b0;
        send_word(32'h304); send_word(32'h305);
        tick();
        chk("geo_flag", 32'(o_geometryError), 32'd1);
        chk("geo_writes", 32'(wq.size()), 32'(4 + HDR));
        vsync_pulse();
        for (int i = 0; i < 12; i++) send_word(32'h400 + 32'(i));
        tick();
        chk("geo_recover_writes", 32'(wq.size()), 32'(16 + 2 * HDR));
        chk("geo_recover_fcount", 32'(o_frameCount), 32'd3);

        // Disarm then rearm clears sticky flags
        i_enable = 1'b0; tick(); tick();
        chk("disarm_busy", 32'(o_busy), 32'd0);
        i_enable = 1'b1; tick();
        chk("rearm_flags", {30'd0, o_overflow, o_geometryError}, 32'd0);

        // Disable at word 5 finishes the frame then idles
        wq.delete(); fsq.delete();
        vsync_pulse();
        for (int i = 0; i < 12; i++) begin
            if (i == 5) i_enable = 1'b0;
            send_word(32'h500 + 32'(i));
        end
        tick();
        chk("dis_writes", 32'(wq.size()), 32'(12 + HDR));
        chk("dis_last_word", wq[wq.size() - 1], 32'h50B);
        chk("dis_fcount", 32'(o_frameCount), 32'd4);
        chk("dis_busy", 32'(o_busy), 32'd0);

        // Reset mid-frame stops writes immediately
        wq.delete(); fsq.delete();
        i_enable = 1'b1; tick();
        vsync_pulse();
        for (int i = 0; i < 3; i++) send_word(32'h600 + 32'(i));
        i_reset = 1'b1; i_dataValid = 1'b1; i_data = 32'h603;
        tick(); i_dataValid = 1'b0; tick();
        chk("midrst_writes", 32'(wq.size()), 32'(3 + HDR));
        chk("midrst_write", 32'(o_fifoWrite), 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_fcount", 32'(o_frameCount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
